// File: rtl/voice_mix_sequencer.sv
// Time-multiplexes one shared sample generator across all voices per codec frame and
// mixes the results. Optional macro VOICE_MIX_HEADROOM_EN halves the mix gain before saturation.
module voice_mix_sequencer #(
  parameter int NUM_VOICES   = 3,
  parameter int SAMPLE_WIDTH = 16,
  parameter int TIMEOUT      = 64
) (
  input  logic                               clk,
  input  logic                               reset,
  input  logic                               new_frame,
  input  logic [NUM_VOICES-1:0]              voice_en,
  output logic                               gen_req,
  output logic [1:0]                         gen_voice,
  input  logic                               gen_ack,
  input  logic [SAMPLE_WIDTH-1:0]            gen_sample,
  output logic [SAMPLE_WIDTH-1:0]            sample_out,
  output logic                               new_sample_generated,
  output logic [NUM_VOICES*SAMPLE_WIDTH-1:0] voice_samples,
  output logic                               busy,
  output logic                               overrun,
  output logic                               timeout_err
);

  localparam int W     = SAMPLE_WIDTH;
  localparam int ACC_W = SAMPLE_WIDTH + 2;
  localparam int CNT_W = $clog2(TIMEOUT) + 1;
  localparam logic signed [ACC_W-1:0] SAT_MAX = {{3{1'b0}}, {(W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] SAT_MIN = {{3{1'b1}}, {(W-1){1'b0}}};

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    SUM  = 2'd2
  } state_t;

  state_t                        state_r;
  state_t                        state_nxt_s;
  logic [NUM_VOICES-1:0]         mask_r;
  logic [NUM_VOICES-1:0]         mask_left_s;
  logic [1:0]                    idx_r;
  logic [1:0]                    idx_nxt_s;
  logic [CNT_W-1:0]              cnt_r;
  logic signed [ACC_W-1:0]       acc_r;
  logic signed [ACC_W-1:0]       acc_sh_s;
  logic [W-1:0]                  cap_s;
  logic [W-1:0]                  mix_s;
  logic                          tmo_s;
  logic                          voice_done_s;
  logic                          gen_req_s;
  logic                          busy_s;
  logic                          pulse_s;
  logic                          gen_req_r;
  logic [1:0]                    gen_voice_r;
  logic [W-1:0]                  sample_out_r;
  logic                          pulse_r;
  logic [NUM_VOICES*W-1:0]       vs_r;
  logic                          busy_r;
  logic                          overrun_r;
  logic                          timeout_err_r;

  function automatic logic [1:0] lowest_idx(input logic [NUM_VOICES-1:0] m);
    logic [1:0] r;
    r = 2'd0;
    for (int i = NUM_VOICES - 1; i >= 0; i--) begin
      if (m[i]) r = 2'(i);
      else      r = r;
    end
    return r;
  endfunction

  function automatic logic [W-1:0] saturate(input logic signed [ACC_W-1:0] a);
    logic [W-1:0] r;
    if (a > SAT_MAX)      r = SAT_MAX[W-1:0];
    else if (a < SAT_MIN) r = SAT_MIN[W-1:0];
    else                  r = a[W-1:0];
    return r;
  endfunction

  // Per-voice handshake bookkeeping: completion, timeout, remaining mask, next index
  always_comb begin
    tmo_s        = (state_r == REQ) && !gen_ack && (cnt_r == CNT_W'(TIMEOUT - 1));
    voice_done_s = (state_r == REQ) && (gen_ack || tmo_s);
    cap_s        = gen_ack ? gen_sample : {W{1'b0}};
    mask_left_s  = mask_r;
    for (int i = 0; i < NUM_VOICES; i++) begin
      if (2'(i) == idx_r) mask_left_s[i] = 1'b0;
      else                mask_left_s[i] = mask_r[i];
    end
    if ((state_r == IDLE) && new_frame) idx_nxt_s = lowest_idx(voice_en);
    else if (voice_done_s)              idx_nxt_s = lowest_idx(mask_left_s);
    else                                idx_nxt_s = idx_r;
  end

  // Mix gain and saturation of the accumulated frame
  always_comb begin
`ifdef VOICE_MIX_HEADROOM_EN
    acc_sh_s = acc_r >>> 1;
`else
    acc_sh_s = acc_r;
`endif
    mix_s = saturate(acc_sh_s);
  end

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_r <= IDLE;
    else        state_r <= state_nxt_s;
  end

  // Next-state logic
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      IDLE: begin
        if (new_frame) state_nxt_s = (voice_en != {NUM_VOICES{1'b0}}) ? REQ : SUM;
        else           state_nxt_s = IDLE;
      end
      REQ: begin
        if (voice_done_s) state_nxt_s = (mask_left_s != {NUM_VOICES{1'b0}}) ? REQ : SUM;
        else              state_nxt_s = REQ;
      end
      SUM:     state_nxt_s = IDLE;
      default: state_nxt_s = IDLE;
    endcase
  end

  // Output decode; values are registered so they line up with the state they describe
  always_comb begin
    gen_req_s = (state_nxt_s == REQ);
    busy_s    = (state_nxt_s != IDLE);
    pulse_s   = (state_r == SUM);
  end

  // Datapath, handshake outputs and sticky flags
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      mask_r        <= {NUM_VOICES{1'b0}};
      idx_r         <= 2'd0;
      cnt_r         <= {CNT_W{1'b0}};
      acc_r         <= {ACC_W{1'b0}};
      vs_r          <= {(NUM_VOICES*W){1'b0}};
      sample_out_r  <= {W{1'b0}};
      pulse_r       <= 1'b0;
      gen_req_r     <= 1'b0;
      gen_voice_r   <= 2'd0;
      busy_r        <= 1'b0;
      overrun_r     <= 1'b0;
      timeout_err_r <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (new_frame) begin
            mask_r <= voice_en;
            acc_r  <= {ACC_W{1'b0}};
            cnt_r  <= {CNT_W{1'b0}};
            for (int i = 0; i < NUM_VOICES; i++) begin
              if (!voice_en[i]) vs_r[i*W +: W] <= {W{1'b0}};
            end
          end
        end
        REQ: begin
          if (voice_done_s) begin
            for (int i = 0; i < NUM_VOICES; i++) begin
              if (2'(i) == idx_r) vs_r[i*W +: W] <= cap_s;
            end
            acc_r  <= acc_r + {{2{cap_s[W-1]}}, cap_s};
            mask_r <= mask_left_s;
            cnt_r  <= {CNT_W{1'b0}};
          end else begin
            cnt_r  <= cnt_r + CNT_W'(1);
          end
        end
        SUM:     sample_out_r <= mix_s;
        default: mask_r <= {NUM_VOICES{1'b0}};
      endcase
      idx_r         <= idx_nxt_s;
      gen_voice_r   <= idx_nxt_s;
      gen_req_r     <= gen_req_s;
      busy_r        <= busy_s;
      pulse_r       <= pulse_s;
      overrun_r     <= overrun_r | (new_frame && (state_r != IDLE));
      timeout_err_r <= timeout_err_r | tmo_s;
    end
  end

  assign gen_req              = gen_req_r;
  assign gen_voice            = gen_voice_r;
  assign sample_out           = sample_out_r;
  assign new_sample_generated = pulse_r;
  assign voice_samples        = vs_r;
  assign busy                 = busy_r;
  assign overrun              = overrun_r;
  assign timeout_err          = timeout_err_r;

endmodule

// File: doc/voice_mix_sequencer.md
Name: voice_mix_sequencer

Overview:
- Per codec frame, sequences one shared voice-sample generator across all voices and sums their results into one mixed sample.
- Sits between the codec's new_frame strobe and the player's sample output path.
- Also exports per-voice samples for the per-voice waveform displays.
- Replaces per-voice parallel generators with one time-multiplexed generator behind a req/ack handshake.

Parameters:
- NUM_VOICES, 3, number of voice slots; legal range 1..4.
- SAMPLE_WIDTH, 16, signed sample width, both in and out.
- TIMEOUT, 64, maximum cycles to wait for gen_ack per voice; must be ≥2.

Ports:
- clk  in  1  system clock (100 MHz domain)
- reset  in  1  asynchronous, active-low reset
- new_frame  in  1  one-cycle strobe from codec requesting the next sample
- voice_en  in  NUM_VOICES  per-voice enable; sampled on the new_frame cycle
- gen_req  out  1  request to shared generator; held until ack
- gen_voice  out  2  voice index of current request
- gen_ack  in  1  generator response valid; only meaningful while gen_req=1
- gen_sample  in  SAMPLE_WIDTH  signed generator output; captured when gen_ack=1
- sample_out  out  SAMPLE_WIDTH  signed mixed sample, registered
- new_sample_generated  out  1  one-cycle pulse when sample_out updates
- voice_samples  out  NUM_VOICES*SAMPLE_WIDTH  per-voice captured samples; voice i at [i*W +: W]
- busy  out  1  high in any state other than IDLE
- overrun  out  1  sticky; set when new_frame arrives while busy
- timeout_err  out  1  sticky; set when any voice times out

Behaviour:
- Reset, asynchronous and active-low, forces the following. State=IDLE. All outputs=0. Accumulator, index, mask and timeout counter=0. Sticky flags clear only on reset.
- States: IDLE, REQ, SUM.
- IDLE + new_frame:
  - Latch voice_en into mask and clear the accumulator.
  - If mask≠0: idx = lowest set bit of mask; go to REQ.
  - If mask=0: go to SUM.
- REQ:
  - gen_req=1 and gen_voice=idx, registered; both stay stable until ack.
  - On gen_ack=1: capture gen_sample into voice_samples[idx]; add sign-extended to the accumulator; clear mask[idx].
  - Then go to REQ with idx = next set bit, or to SUM if none remain.
  - gen_req deasserts the cycle after ack only when going to SUM. Otherwise it stays high with the new gen_voice.
- Disabled voices:
  - Skipped in zero cycles.
  - Their voice_samples entry is written to 0 on the new_frame cycle.
- Timeout:
  - Counter resets on entry to each voice and increments each REQ cycle without ack.
  - At TIMEOUT cycles without ack, the voice is treated as acked with sample 0, and timeout_err is set.
- Accumulator: SAMPLE_WIDTH+2 bits, signed.
- SUM (one cycle):
  - Saturate the accumulator to the SAMPLE_WIDTH signed range: +32767 / −32768 at the default width.
  - Result is registered into sample_out; new_sample_generated=1 at the same edge.
  - Return to IDLE.
- Latency, with ack in the first REQ cycle for every voice:
  - new_frame at T; REQ at T+1..T+N for N enabled voices; SUM at T+N+1.
  - sample_out and pulse visible at T+N+2.
- With all voices disabled: pulse at T+2 with sample_out=0.
- new_frame while busy:
  - Ignored; the frame in progress completes unaffected; overrun set.
  - sample_out holds its previous value until the in-progress frame's SUM.
- gen_ack while gen_req=0: ignored.
- voice_en changes mid-frame: no effect until the next new_frame.
- Reset mid-frame: immediate return to IDLE with outputs cleared. The generator must tolerate gen_req dropping without an ack.

Optional Feature:
- Macro: VOICE_MIX_HEADROOM_EN.
- Defined: the accumulator is arithmetically shifted right by 1 before saturation, giving halved mix gain and 6 dB headroom. Truncation is toward −∞.
- Undefined: no shift; saturation only.
- Per-voice voice_samples are never shifted in either build.

Test Plan:
- Defaults, voice_en=3'b111, ack in the same cycle as req; samples 1000, −200, 50 → gen_voice 0,1,2 on T+1..T+3; pulse at T+5; sample_out=850; voice_samples={50,−200,1000}.
- voice_en=3'b101, samples 30000 and 10000 → only voices 0 and 2 requested; sample_out=32767 (saturated). With VOICE_MIX_HEADROOM_EN: 20000.
- voice_en=3'b000 → no gen_req; pulse at T+2; sample_out=0; voice_samples all 0.
- voice_en=3'b010, gen_ack withheld → gen_req held 64 cycles, then SUM; sample_out=0; timeout_err=1 and stays 1 after further good frames.
- Second new_frame 2 cycles after the first, with ack delayed 5 cycles per voice → single pulse; overrun=1; result equals the first frame's mix.
- reset pulled low during REQ for voice 1 → gen_req, busy and sample_out=0 immediately. After release, the next new_frame produces a correct full mix.
